md_debug_access_bridge: RTL and testbench
=========================================

// Module: md_debug_access_bridge
// PURPOSE
//  Parametrised register-to-element debug access engine for the MD kernel control path. Sits behind the
//  AXI4-Lite slave's simple register port. Assembles a wide element word (d_in) from 32-bit register
//  writes and issues acked write/read requests to one of NUM_CH MD cores. Captures the selected core's
//  d_out into read-back shadow registers. Generates a timed debug reset pulse.
// PARAMETERS
//  REG_DATA_WIDTH    32    register port data width (fixed 32)
//  REG_ADDR_WIDTH    9     register byte-address width
//  DIN_WIDTH         210   element write width; DIN_WORDS = ceil(DIN_WIDTH/32)
//  DOUT_WIDTH        192   element read width; DOUT_WORDS = ceil(DOUT_WIDTH/32)
//  NUM_CH            4     number of MD cores addressed (1..256)
//  TIMEOUT_CYCLES    1024  max cycles a request waits for elem_ack
//  RST_PULSE_CYCLES  16    debug_reset_n low duration in cycles
// PORTS
//  ap_clk        in   1                  system clock
//  ap_rst        in   1                  asynchronous, active-high reset
//  reg_wr        in   1                  register write strobe (single cycle)
//  reg_waddr     in   REG_ADDR_WIDTH     write byte address
//  reg_wdata     in   32                 write data
//  reg_rd        in   1                  register read strobe
//  reg_raddr     in   REG_ADDR_WIDTH     read byte address
//  reg_rdata     out  32                 read data, valid with reg_rvalid
//  reg_rvalid    out  1                  read data valid pulse
//  d_in          out  DIN_WIDTH          element data to cores (shared bus)
//  elem_write    out  NUM_CH             per-core write request, held until ack
//  elem_read     out  NUM_CH             per-core read request, held until ack
//  elem_ack      in   NUM_CH             per-core request acknowledge
//  d_out         in   NUM_CH*DOUT_WIDTH  per-core element data; core k at [k*DOUT_WIDTH +: DOUT_WIDTH]
//  debug_reset_n out  1                  active-low debug reset pulse to cores
//  busy          out  1                  request or reset pulse in progress
// BEHAVIOUR
//  Register map (word aligned; other addresses read 0, writes ignored):
//   0x000 CTRL   W: b0 start write, b1 start read, b2 debug reset, b[15:8] channel. R: last CTRL value.
//   0x004 STATUS R: b0 busy, b1 done, b2 timeout, b3 error (sticky). W1C clears b1..b3.
//   0x008 CYCLES R: cycles from request assert to ack/timeout of the last op (saturates at 2^32-1).
//   0x040+4k DIN[k], k<DIN_WORDS, R/W; bits of the top word at or above DIN_WIDTH read 0.
//   0x080+4k DOUT[k], k<DOUT_WORDS, R only (shadow of last captured d_out).
//  Reset: all outputs 0 except debug_reset_n=1. DIN, DOUT, STATUS, CYCLES, CTRL all 0.
//  Read latency: reg_rvalid pulses exactly 1 cycle after reg_rd with reg_rdata registered.
//  FSM states IDLE, WREQ, RREQ, RSTP.
//   IDLE: CTRL write with exactly one of b0/b1/b2 set and channel<NUM_CH -> WREQ/RREQ/RSTP.
//   Otherwise (no bits, more than one bit, or bad channel) set error and stay in IDLE.
//   WREQ: elem_write[ch]=1 from the cycle after the CTRL write. On elem_ack[ch]: deassert next cycle,
//   set done, go to IDLE.
//   RREQ: same handshake with elem_read. On ack, capture d_out slice ch into DOUT the same edge.
//   Timeout: TIMEOUT_CYCLES request cycles without ack -> deassert, set timeout, IDLE, DOUT unchanged.
//   Ack in the final timeout cycle counts as success.
//   RSTP: debug_reset_n=0 for exactly RST_PULSE_CYCLES cycles, then 1; set done; IDLE. Channel ignored.
//  busy = (state != IDLE). DIN and CTRL writes while busy are ignored and set error, so d_in stays stable.
//  Acks on non-selected channels and acks in IDLE are ignored.
//  STATUS W1C in the same cycle as a set event: set wins.
//  At most one elem_write/elem_read bit is high at any time.
//  Reset mid-operation: requests drop and debug_reset_n returns to 1 asynchronously. FSM returns to IDLE.
// TESTING
//  1. Write DIN0..6 = 0x11111111..0x77777777, CTRL=0x0201, ack ch2 after 5 cycles.
//     -> d_in[209:192]=0x37777, elem_write=4'b0100 for 5 cycles, STATUS=0x2, CYCLES=5.
//  2. d_out ch1 = 192'hA5..A5, CTRL=0x0102, ack after 3 cycles.
//     -> DOUT0..5 read 0xA5A5A5A5, STATUS=0x2, reg_rvalid 1 cycle after each reg_rd.
//  3. CTRL=0x0102, no ack. -> elem_read[1] high for exactly 1024 cycles, then STATUS=0x4, DOUT unchanged.
//  4. Error cases:
//     - CTRL=0x0501 (ch 5 >= NUM_CH) -> STATUS=0x8, no request.
//     - CTRL=0x0003 -> error, no request.
//     - DIN write while busy -> error, d_in unchanged.
//  5. CTRL=0x0004 -> debug_reset_n low exactly 16 cycles, busy high for the same 16 cycles, then done.
//  6. ap_rst asserted mid-RREQ -> elem_read=0 and busy=0 without a clock edge; all registers read 0 after.

Source files
------------

// File: rtl/md_debug_access_bridge_if.sv
// Register-port and MD-core element-port bundle for md_debug_access_bridge.
// The slave modport is the bridge; the master modport is the register host plus the cores.
interface md_debug_access_bridge_if #(
    parameter int REG_ADDR_WIDTH = 9,
    parameter int DIN_WIDTH      = 210,
    parameter int DOUT_WIDTH     = 192,
    parameter int NUM_CH         = 4
);
    logic                         reg_wr;
    logic [REG_ADDR_WIDTH-1:0]    reg_waddr;
    logic [31:0]                  reg_wdata;
    logic                         reg_rd;
    logic [REG_ADDR_WIDTH-1:0]    reg_raddr;
    logic [31:0]                  reg_rdata;
    logic                         reg_rvalid;
    logic [DIN_WIDTH-1:0]         d_in;
    logic [NUM_CH-1:0]            elem_write;
    logic [NUM_CH-1:0]            elem_read;
    logic [NUM_CH-1:0]            elem_ack;
    logic [NUM_CH*DOUT_WIDTH-1:0] d_out;
    logic                         debug_reset_n;
    logic                         busy;

    modport slave (
        input  reg_wr, reg_waddr, reg_wdata, reg_rd, reg_raddr, elem_ack, d_out,
        output reg_rdata, reg_rvalid, d_in, elem_write, elem_read, debug_reset_n, busy
    );

    modport master (
        output reg_wr, reg_waddr, reg_wdata, reg_rd, reg_raddr, elem_ack, d_out,
        input  reg_rdata, reg_rvalid, d_in, elem_write, elem_read, debug_reset_n, busy
    );
endinterface

// File: rtl/md_debug_access_bridge.sv
// Register-driven debug access engine: assembles element words, issues acked write/read
// requests to one of NUM_CH MD cores, shadows read data and generates a timed debug reset.
module md_debug_access_bridge #(
    parameter int REG_DATA_WIDTH   = 32,
    parameter int REG_ADDR_WIDTH   = 9,
    parameter int DIN_WIDTH        = 210,
    parameter int DOUT_WIDTH       = 192,
    parameter int NUM_CH           = 4,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int RST_PULSE_CYCLES = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    md_debug_access_bridge_if.slave bus
);
    localparam int DIN_BASE  = 16;  // word index of 0x040
    localparam int DOUT_BASE = 32;  // word index of 0x080
    localparam int DIN_WORDS = (DIN_WIDTH + 31) / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WREQ = 2'd1,
        RREQ = 2'd2,
        RSTP = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [7:0]                ch_r, ch_s;
    logic [REG_DATA_WIDTH-1:0] cnt_r, cnt_s, req_cycles_s;
    logic [REG_DATA_WIDTH-1:0] cycles_r, cycles_s, ctrl_r, rd_mux_s, reg_rdata_r;
    logic                      done_r, timeout_r, error_r, busy_r, reg_rvalid_r, debug_reset_n_r;
    logic                      done_set_s, timeout_set_s, err_set_s, capture_s;
    logic [DIN_WIDTH-1:0]      din_r, din_wr_s;
    logic [DOUT_WIDTH-1:0]     dout_r, dout_sel_s;
    logic [31:0]               din_rd_s, dout_rd_s;
    logic [NUM_CH-1:0]         elem_write_r, elem_read_r;
    logic                      wr_aligned_s, wr_ctrl_s, wr_status_s, wr_din_s, idle_s;
    logic                      cmd_valid_s, ack_sel_s;
    int                        wr_k_s, rd_k_s;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [7:0] ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v[k] = (ch == 8'(k));
        end
        return v;
    endfunction

    assign wr_k_s       = int'(bus.reg_waddr[REG_ADDR_WIDTH-1:2]);
    assign rd_k_s       = int'(bus.reg_raddr[REG_ADDR_WIDTH-1:2]);
    assign wr_aligned_s = (bus.reg_waddr[1:0] == 2'b00);
    assign wr_ctrl_s    = bus.reg_wr && wr_aligned_s && (wr_k_s == 0);
    assign wr_status_s  = bus.reg_wr && wr_aligned_s && (wr_k_s == 1);
    assign wr_din_s     = bus.reg_wr && wr_aligned_s && (wr_k_s >= DIN_BASE) && (wr_k_s < DIN_BASE + DIN_WORDS);
    assign idle_s       = (state_r == IDLE);
    assign cmd_valid_s  = $onehot(bus.reg_wdata[2:0]) && (32'(bus.reg_wdata[15:8]) < 32'(NUM_CH));
    assign ack_sel_s    = |(bus.elem_ack & ch_onehot(ch_r));
    assign req_cycles_s = (cnt_r == '1) ? cnt_r : cnt_r + REG_DATA_WIDTH'(1);
    // A busy engine rejects DIN/CTRL writes so d_in and the active request stay stable.
    assign err_set_s    = idle_s ? (wr_ctrl_s && !cmd_valid_s) : (wr_ctrl_s || wr_din_s);

    // Merge an incoming DIN word into the element image; bits past DIN_WIDTH fall away.
    always_comb begin
        din_wr_s = din_r;
        for (int b = 0; b < DIN_WIDTH; b++) begin
            din_wr_s[b] = ((b / 32) == (wr_k_s - DIN_BASE)) ? bus.reg_wdata[b % 32] : din_r[b];
        end
    end

    // Read-side word extraction of DIN and DOUT images, zero-padded above the element width.
    always_comb begin
        din_rd_s  = '0;
        dout_rd_s = '0;
        for (int b = 0; b < DIN_WIDTH; b++) begin
            din_rd_s[b % 32] = din_rd_s[b % 32] | (din_r[b] & ((b / 32) == (rd_k_s - DIN_BASE)));
        end
        for (int b = 0; b < DOUT_WIDTH; b++) begin
            dout_rd_s[b % 32] = dout_rd_s[b % 32] | (dout_r[b] & ((b / 32) == (rd_k_s - DOUT_BASE)));
        end
    end

    // Select the d_out slice of the active channel.
    always_comb begin
        dout_sel_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            dout_sel_s = dout_sel_s | (bus.d_out[k*DOUT_WIDTH +: DOUT_WIDTH] & {DOUT_WIDTH{ch_r == 8'(k)}});
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = '0;
        if (bus.reg_raddr[1:0] != 2'b00) begin
            rd_mux_s = '0;
        end else if (rd_k_s == 0) begin
            rd_mux_s = ctrl_r;
        end else if (rd_k_s == 1) begin
            rd_mux_s = {{(REG_DATA_WIDTH-4){1'b0}}, error_r, timeout_r, done_r, busy_r};
        end else if (rd_k_s == 2) begin
            rd_mux_s = cycles_r;
        end else if ((rd_k_s >= DIN_BASE) && (rd_k_s < DOUT_BASE)) begin
            rd_mux_s = din_rd_s;
        end else begin
            rd_mux_s = dout_rd_s;
        end
    end

    // Next-state logic and operation completion events.
    always_comb begin
        state_s       = state_r;
        ch_s          = ch_r;
        cnt_s         = cnt_r;
        cycles_s      = cycles_r;
        done_set_s    = 1'b0;
        timeout_set_s = 1'b0;
        capture_s     = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (wr_ctrl_s && cmd_valid_s) begin
                    ch_s = bus.reg_wdata[15:8];
                    case (bus.reg_wdata[2:0])
                        3'b001:  state_s = WREQ;
                        3'b010:  state_s = RREQ;
                        3'b100:  state_s = RSTP;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WREQ, RREQ: begin
                // Ack has priority, so an ack in the final timeout cycle still succeeds.
                if (ack_sel_s) begin
                    cycles_s   = req_cycles_s;
                    done_set_s = 1'b1;
                    capture_s  = (state_r == RREQ);
                    cnt_s      = '0;
                    state_s    = IDLE;
                end else if (req_cycles_s == REG_DATA_WIDTH'(TIMEOUT_CYCLES)) begin
                    cycles_s      = req_cycles_s;
                    timeout_set_s = 1'b1;
                    cnt_s         = '0;
                    state_s       = IDLE;
                end else begin
                    cnt_s = req_cycles_s;
                end
            end
            RSTP: begin
                if (req_cycles_s == REG_DATA_WIDTH'(RST_PULSE_CYCLES)) begin
                    done_set_s = 1'b1;
                    cnt_s      = '0;
                    state_s    = IDLE;
                end else begin
                    cnt_s = req_cycles_s;
                end
            end
            default: begin
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, channel and cycle counter.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r  <= IDLE;
            ch_r     <= 8'd0;
            cnt_r    <= '0;
            cycles_r <= '0;
        end else begin
            state_r  <= state_s;
            ch_r     <= ch_s;
            cnt_r    <= cnt_s;
            cycles_r <= cycles_s;
        end
    end

    // Registered core-side outputs derived from the next state.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            elem_write_r    <= '0;
            elem_read_r     <= '0;
            debug_reset_n_r <= 1'b1;
            busy_r          <= 1'b0;
        end else begin
            elem_write_r    <= (state_s == WREQ) ? ch_onehot(ch_s) : '0;
            elem_read_r     <= (state_s == RREQ) ? ch_onehot(ch_s) : '0;
            debug_reset_n_r <= (state_s != RSTP);
            busy_r          <= (state_s != IDLE);
        end
    end

    // Register file: CTRL, sticky STATUS with W1C (set wins), DIN image and DOUT shadow.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ctrl_r    <= '0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            error_r   <= 1'b0;
            din_r     <= '0;
            dout_r    <= '0;
        end else begin
            if (wr_ctrl_s && idle_s) begin
                ctrl_r <= bus.reg_wdata;
            end
            if (wr_din_s && idle_s) begin
                din_r <= din_wr_s;
            end
            if (capture_s) begin
                dout_r <= dout_sel_s;
            end
            done_r    <= done_set_s    | (done_r    & ~(wr_status_s & bus.reg_wdata[1]));
            timeout_r <= timeout_set_s | (timeout_r & ~(wr_status_s & bus.reg_wdata[2]));
            error_r   <= err_set_s     | (error_r   & ~(wr_status_s & bus.reg_wdata[3]));
        end
    end

    // Read port: data and valid one cycle after the strobe.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            reg_rvalid_r <= 1'b0;
            reg_rdata_r  <= '0;
        end else begin
            reg_rvalid_r <= bus.reg_rd;
            if (bus.reg_rd) begin
                reg_rdata_r <= rd_mux_s;
            end
        end
    end

    assign bus.reg_rdata     = reg_rdata_r;
    assign bus.reg_rvalid    = reg_rvalid_r;
    assign bus.d_in          = din_r;
    assign bus.elem_write    = elem_write_r;
    assign bus.elem_read     = elem_read_r;
    assign bus.debug_reset_n = debug_reset_n_r;
    assign bus.busy          = busy_r;
endmodule

// File: tb/tb_md_debug_access_bridge.sv
// Directed bench for md_debug_access_bridge: register writes/reads, element handshakes,
// timeout, error paths, debug reset pulse and asynchronous reset.
module tb_md_debug_access_bridge;
    localparam logic [8:0] A_CTRL   = 9'h000;
    localparam logic [8:0] A_STATUS = 9'h004;
    localparam logic [8:0] A_CYCLES = 9'h008;
    localparam logic [8:0] A_DIN    = 9'h040;
    localparam logic [8:0] A_DOUT   = 9'h080;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    int   hi;
    int   lo;
    int   bz;

    md_debug_access_bridge_if #(.REG_ADDR_WIDTH(9), .DIN_WIDTH(210), .DOUT_WIDTH(192), .NUM_CH(4)) bus ();

    md_debug_access_bridge dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        bus.reg_wr    = 1'b1;
        bus.reg_waddr = a;
        bus.reg_wdata = d;
        tick();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [8:0] a, input logic [31:0] exp);
        bus.reg_rd    = 1'b1;
        bus.reg_raddr = a;
        tick();
        bus.reg_rd    = 1'b0;
        chk({tag, "_rvalid"}, 256'(bus.reg_rvalid), 256'(1'b1));
        chk(tag, 256'(bus.reg_rdata), 256'(exp));
        tick();
        chk({tag, "_rvalid_drop"}, 256'(bus.reg_rvalid), 256'(1'b0));
    endtask

    initial begin
        bus.reg_wr    = 1'b0;
        bus.reg_waddr = 9'h000;
        bus.reg_wdata = 32'h0;
        bus.reg_rd    = 1'b0;
        bus.reg_raddr = 9'h000;
        bus.elem_ack  = 4'b0000;
        bus.d_out     = '0;
        tick();
        tick();
        ap_rst = 1'b0;
        tick();

        // Reset state
        chk("rst_d_in", 256'(bus.d_in), 256'(0));
        chk("rst_elem_write", 256'(bus.elem_write), 256'(4'b0000));
        chk("rst_elem_read", 256'(bus.elem_read), 256'(4'b0000));
        chk("rst_dbg_n", 256'(bus.debug_reset_n), 256'(1'b1));
        chk("rst_busy", 256'(bus.busy), 256'(1'b0));
        rd_chk("rst_status", A_STATUS, 32'h0);

        // 1: element write on ch2, ack in the 5th request cycle together with a W1C of done
        for (int k = 0; k < 7; k++) wr(A_DIN + 9'(4 * k), 32'h11111111 * 32'(k + 1));
        chk("t1_d_in_top", 256'(bus.d_in[209:192]), 256'(18'h37777));
        chk("t1_d_in_w0", 256'(bus.d_in[31:0]), 256'(32'h11111111));
        rd_chk("t1_din6_rb", A_DIN + 9'h018, 32'h00037777);
        wr(A_CTRL, 32'h0000_0201);
        for (int i = 1; i <= 5; i++) begin
            chk("t1_elem_write", 256'(bus.elem_write), 256'(4'b0100));
            if (i == 5) begin
                bus.elem_ack  = 4'b0100;
                bus.reg_wr    = 1'b1;
                bus.reg_waddr = A_STATUS;
                bus.reg_wdata = 32'h2;
            end
            tick();
        end
        bus.elem_ack = 4'b0000;
        bus.reg_wr   = 1'b0;
        chk("t1_write_drop", 256'(bus.elem_write), 256'(4'b0000));
        chk("t1_busy_drop", 256'(bus.busy), 256'(1'b0));
        rd_chk("t1_status", A_STATUS, 32'h2);
        rd_chk("t1_cycles", A_CYCLES, 32'd5);

        // 2: element read on ch1, ack after 3 cycles, capture into DOUT
        bus.d_out[1*192 +: 192] = {24{8'hA5}};
        bus.d_out[2*192 +: 192] = {24{8'h3C}};
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0102);
        for (int i = 1; i <= 3; i++) begin
            chk("t2_elem_read", 256'(bus.elem_read), 256'(4'b0010));
            if (i == 3) bus.elem_ack = 4'b0010;
            tick();
        end
        bus.elem_ack = 4'b0000;
        chk("t2_read_drop", 256'(bus.elem_read), 256'(4'b0000));
        for (int k = 0; k < 6; k++) rd_chk("t2_dout", A_DOUT + 9'(4 * k), 32'hA5A5A5A5);
        rd_chk("t2_status", A_STATUS, 32'h2);
        rd_chk("t2_cycles", A_CYCLES, 32'd3);

        // 3: read on ch1 with no ack -> timeout after 1024 request cycles, DOUT unchanged
        bus.d_out[1*192 +: 192] = {24{8'h5A}};
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0102);
        hi = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.elem_read == 4'b0010) hi++;
            else break;
            tick();
        end
        chk("t3_read_high_cycles", 256'(hi), 256'(1024));
        chk("t3_read_drop", 256'(bus.elem_read), 256'(4'b0000));
        rd_chk("t3_status", A_STATUS, 32'h4);
        rd_chk("t3_cycles", A_CYCLES, 32'd1024);
        rd_chk("t3_dout_kept", A_DOUT, 32'hA5A5A5A5);

        // Ack in the final timeout cycle counts as success
        bus.d_out[0 +: 192] = {24{8'hC3}};
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0002);
        for (int i = 1; i <= 1024; i++) begin
            if (i == 1024) bus.elem_ack = 4'b0001;
            tick();
        end
        bus.elem_ack = 4'b0000;
        chk("t3b_read_drop", 256'(bus.elem_read), 256'(4'b0000));
        rd_chk("t3b_status", A_STATUS, 32'h2);
        rd_chk("t3b_cycles", A_CYCLES, 32'd1024);
        rd_chk("t3b_dout", A_DOUT + 9'h014, 32'hC3C3C3C3);

        // 4: error cases
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0501);
        chk("t4_badch_no_req", 256'(bus.elem_write), 256'(4'b0000));
        chk("t4_badch_busy", 256'(bus.busy), 256'(1'b0));
        rd_chk("t4_badch_status", A_STATUS, 32'h8);
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0003);
        chk("t4_multi_no_wr", 256'(bus.elem_write), 256'(4'b0000));
        chk("t4_multi_no_rd", 256'(bus.elem_read), 256'(4'b0000));
        rd_chk("t4_multi_status", A_STATUS, 32'h8);
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0001);
        chk("t4_busy_req", 256'(bus.elem_write), 256'(4'b0001));
        wr(A_DIN, 32'hDEADBEEF);
        chk("t4_d_in_stable", 256'(bus.d_in[31:0]), 256'(32'h11111111));
        chk("t4_busy", 256'(bus.busy), 256'(1'b1));
        bus.elem_ack = 4'b1000;
        tick();
        bus.elem_ack = 4'b0000;
        chk("t4_other_ack_ignored", 256'(bus.elem_write), 256'(4'b0001));
        bus.elem_ack = 4'b0001;
        tick();
        bus.elem_ack = 4'b0000;
        chk("t4_write_drop", 256'(bus.elem_write), 256'(4'b0000));
        rd_chk("t4_busy_status", A_STATUS, 32'hA);
        rd_chk("t4_cycles", A_CYCLES, 32'd3);
        rd_chk("t4_din0_kept", A_DIN, 32'h11111111);

        // 5: debug reset pulse
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, 32'h0000_0004);
        lo = 0;
        bz = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.debug_reset_n == 1'b0) lo++;
            if (bus.busy == 1'b1) bz++;
            if (bus.debug_reset_n == 1'b1 && bus.busy == 1'b0) break;
            tick();
        end
        chk("t5_low_cycles", 256'(lo), 256'(16));
        chk("t5_busy_cycles", 256'(bz), 256'(16));
        chk("t5_no_elem_write", 256'(bus.elem_write), 256'(4'b0000));
        rd_chk("t5_status", A_STATUS, 32'h2);
        rd_chk("t5_ctrl", A_CTRL, 32'h0000_0004);

        // 6: asynchronous reset in the middle of a read request
        wr(A_CTRL, 32'h0000_0102);
        tick();
        chk("t6_pre_read", 256'(bus.elem_read), 256'(4'b0010));
        chk("t6_pre_busy", 256'(bus.busy), 256'(1'b1));
        #2;
        ap_rst = 1'b1;
        #1;
        chk("t6_async_read", 256'(bus.elem_read), 256'(4'b0000));
        chk("t6_async_busy", 256'(bus.busy), 256'(1'b0));
        chk("t6_async_dbg_n", 256'(bus.debug_reset_n), 256'(1'b1));
        chk("t6_async_d_in", 256'(bus.d_in), 256'(0));
        tick();
        ap_rst = 1'b0;
        tick();
        rd_chk("t6_ctrl", A_CTRL, 32'h0);
        rd_chk("t6_status", A_STATUS, 32'h0);
        rd_chk("t6_cycles", A_CYCLES, 32'h0);
        rd_chk("t6_din0", A_DIN, 32'h0);
        rd_chk("t6_dout0", A_DOUT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
